alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_md_iter.sv | 92 +++++++++
 rtl/alu_md.sv | 125 ++++++++++++
 tb/tb_alu_md.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and multiply/divide sequencer state
package alu_pkg;

    localparam logic [3:0] ALUC_ADD   = 4'b0000;
    localparam logic [3:0] ALUC_SUB   = 4'b0100;
    localparam logic [3:0] ALUC_AND   = 4'b0001;
    localparam logic [3:0] ALUC_OR    = 4'b0101;
    localparam logic [3:0] ALUC_XOR   = 4'b0010;
    localparam logic [3:0] ALUC_LUI   = 4'b0110;
    localparam logic [3:0] ALUC_SLL   = 4'b0011;
    localparam logic [3:0] ALUC_SRL   = 4'b0111;
    localparam logic [3:0] ALUC_SRA   = 4'b1111;
    localparam logic [3:0] ALUC_MULTU = 4'b1000;
    localparam logic [3:0] ALUC_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == ALUC_MULTU) || (op == ALUC_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// rtl/alu_md_iter.sv - one-bit-per-cycle shift-add multiply / restoring divide datapath
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = SHW + 1;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_sr;

    // acc:sr forms one double-width register; multiply shifts it right, divide shifts it left
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, sr_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (div_q) begin
            if (!div_trial[WIDTH]) begin
                step_acc = div_trial[WIDTH-1:0];
                step_sr  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_sr  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_sr  = {mul_sum[0], sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_d  = acc_q;
        sr_d   = sr_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (load) begin
            acc_d  = '0;
            sr_d   = a;
            opnd_d = b;
            div_d  = div_sel;
            cnt_d  = '0;
        end else if (step) begin
            acc_d = step_acc;
            sr_d  = step_sr;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc_q  <= '0;
            sr_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            sr_q   <= sr_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign res_hi = step_acc;
    assign res_lo = step_sr;

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - ALU with single-cycle ops plus iterative unsigned multiply and divide
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [3:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             z_q, z_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             ready;
    logic             iter_load;
    logic             iter_step;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    always_comb begin
        shamt = a[SHW-1:0];
        case (aluc)
            ALUC_ADD: alu_res = a + b;
            ALUC_SUB: alu_res = a - b;
            ALUC_AND: alu_res = a & b;
            ALUC_OR:  alu_res = a | b;
            ALUC_XOR: alu_res = a ^ b;
            ALUC_LUI: alu_res = b << (WIDTH / 2);
            ALUC_SLL: alu_res = b << shamt;
            ALUC_SRL: alu_res = b >> shamt;
            ALUC_SRA: alu_res = $signed(b) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign iter_step = (state_q == ST_RUN);

    // DONE accepts a new start directly so back-to-back ops have no idle bubble
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        iter_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (ready && start) begin
                    if (is_multi(aluc)) begin
                        iter_load = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        s_d     = alu_res;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (iter_last) begin
                    hi_d    = iter_hi;
                    lo_d    = iter_lo;
                    s_d     = iter_lo;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        z_d = (s_d == '0);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            z_q     <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clock   (clock),
        .resetn  (resetn),
        .load    (iter_load),
        .div_sel (aluc == ALUC_DIVU),
        .a       (a),
        .b       (b),
        .step    (iter_step),
        .last    (iter_last),
        .res_hi  (iter_hi),
        .res_lo  (iter_lo)
    );

    assign s    = s_q;
    assign z    = z_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed self-checking bench for alu_md at WIDTH 32 and 8
module tb_alu_md;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [3:0]  aluc;
    logic [31:0] a, b, s, hi, lo;
    logic        z, busy, done;

    logic        start8;
    logic [3:0]  aluc8;
    logic [7:0]  a8, b8, s8, hi8, lo8;
    logic        z8, busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(32)) dut (
        .clock(clk), .resetn(resetn), .start(start), .aluc(aluc), .a(a), .b(b),
        .s(s), .z(z), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    alu_md #(.WIDTH(8)) dut8 (
        .clock(clk), .resetn(resetn), .start(start8), .aluc(aluc8), .a(a8), .b(b8),
        .s(s8), .z(z8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
    );

    task automatic issue(input logic [3:0] op, input logic [31:0] oa, input logic [31:0] ob);
        @(posedge clk); #1;
        start = 1'b1; aluc = op; a = oa; b = ob;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_n);
        edges  = 1;
        busy_n = 0;
        while (!done && edges < 200) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b1; aluc = ALUC_ADD; a = 32'd1; b = 32'd1;
        start8 = 1'b0; aluc8 = 4'd0; a8 = 8'd0; b8 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (s !== 32'h0) begin n_fail++; $display("FAIL reset_s: got %h want %h", s, 32'h0); end
        n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL reset_z: got %b want 1", z); end
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); end
        resetn = 1'b1; start = 1'b0;
    endtask

    task automatic test_add_sub();
        issue(ALUC_ADD, 32'hFFFF_FFFF, 32'h1);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b want 1", done); end
        n_checks++; if (s !== 32'h0 || z !== 1'b1) begin n_fail++; $display("FAIL add_wrap: got s=%h z=%b want s=0 z=1", s, z); end
        issue(ALUC_SUB, 32'd5, 32'd7);
        n_checks++; if (s !== 32'hFFFF_FFFE || z !== 1'b0) begin n_fail++; $display("FAIL sub: got s=%h z=%b want s=fffffffe z=0", s, z); end
    endtask

    task automatic test_logic();
        logic [3:0]  ops [4]  = '{ALUC_AND, ALUC_OR, ALUC_XOR, 4'b1010};
        logic [31:0] want [4] = '{32'h0000_F000, 32'h0000_FFF0, 32'h0000_0FF0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'h0000_F0F0, 32'h0000_FF00);
            n_checks++;
            if (s !== want[i] || z !== (want[i] == 32'h0)) begin
                n_fail++; $display("FAIL logic_op%0d: got s=%h z=%b want s=%h", i, s, z, want[i]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [5]  = '{ALUC_SRA, ALUC_SRL, ALUC_LUI, ALUC_SLL, ALUC_SRL};
        logic [31:0] oa [5]   = '{32'd4, 32'd4, 32'd0, 32'd4, 32'h21};
        logic [31:0] ob [5]   = '{32'h8000_0000, 32'h8000_0000, 32'h1234, 32'h1, 32'h8000_0000};
        logic [31:0] want [5] = '{32'hF800_0000, 32'h0800_0000, 32'h1234_0000, 32'h10, 32'h4000_0000};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], oa[i], ob[i]);
            n_checks++;
            if (s !== want[i]) begin n_fail++; $display("FAIL shift%0d: got %h want %h", i, s, want[i]); end
        end
    endtask

    task automatic test_multu();
        int edges, busy_n;
        issue(ALUC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        edges = 1; busy_n = 0;
        while (!done && edges < 200) begin
            if (busy) busy_n++;
            if (edges == 5) begin start = 1'b1; aluc = ALUC_ADD; a = 32'd1; b = 32'd2; end
            if (edges == 8) start = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL multu_latency: done at edge %0d want 33", edges); end
        n_checks++; if (busy_n !== 32) begin n_fail++; $display("FAIL multu_busy: busy %0d cycles want 32", busy_n); end
        n_checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin n_fail++; $display("FAIL multu_prod: got %h_%h want fffffffe_00000001", hi, lo); end
        n_checks++; if (s !== 32'h1 || z !== 1'b0) begin n_fail++; $display("FAIL multu_s: got s=%h z=%b want 1/0", s, z); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || s !== 32'h1) begin n_fail++; $display("FAIL multu_pulse: got done=%b s=%h want 0/1", done, s); end
        issue(ALUC_MULTU, 32'd0, 32'd5);
        wait_done(edges, busy_n);
        n_checks++; if (s !== 32'h0 || z !== 1'b1) begin n_fail++; $display("FAIL multu_zero: got s=%h z=%b want 0/1", s, z); end
    endtask

    task automatic test_divu();
        int edges, busy_n;
        issue(ALUC_DIVU, 32'd100, 32'd7);
        wait_done(edges, busy_n);
        n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL divu_latency: done at edge %0d want 33", edges); end
        n_checks++; if (lo !== 32'd14 || hi !== 32'd2 || s !== 32'd14) begin n_fail++; $display("FAIL divu: got lo=%h hi=%h s=%h want e/2/e", lo, hi, s); end
        issue(ALUC_DIVU, 32'd9, 32'd0);
        wait_done(edges, busy_n);
        n_checks++; if (edges !== 33) begin n_fail++; $display("FAIL divu0_latency: done at edge %0d want 33", edges); end
        n_checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'd9 || s !== 32'hFFFF_FFFF || z !== 1'b0) begin
            n_fail++; $display("FAIL divu0: got lo=%h hi=%h s=%h z=%b want ffffffff/9/ffffffff/0", lo, hi, s, z);
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_n;
        @(posedge clk); #1;
        start = 1'b1; aluc = ALUC_ADD; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1 || s !== 32'd5) begin n_fail++; $display("FAIL b2b_add: got done=%b s=%h want 1/5", done, s); end
        n_checks++; if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_hilo_hold: got %h/%h want 9/ffffffff", hi, lo); end
        aluc = ALUC_MULTU; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_nobubble: got busy=%b done=%b want 1/0", busy, done); end
        wait_done(edges, busy_n);
        n_checks++; if (edges !== 33 || lo !== 32'd15 || hi !== 32'd0 || s !== 32'd15) begin
            n_fail++; $display("FAIL b2b_multu: got edge=%0d hi=%h lo=%h s=%h want 33/0/f/f", edges, hi, lo, s);
        end
    endtask

    task automatic test_reset_during_run();
        int seen_done = 0;
        issue(ALUC_MULTU, 32'd7, 32'd9);
        repeat (9) begin @(posedge clk); #1; end
        resetn = 1'b0; start = 1'b1; aluc = ALUC_ADD; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        n_checks++;
        if (s !== 32'h0 || z !== 1'b1 || hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL run_reset: got s=%h z=%b hi=%h lo=%h busy=%b done=%b want reset values", s, z, hi, lo, busy, done);
        end
        resetn = 1'b1; start = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done) seen_done++; end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL run_reset_nodone: got %0d done cycles want 0", seen_done); end
    endtask

    task automatic test_width8();
        int edges = 1;
        @(posedge clk); #1;
        start8 = 1'b1; aluc8 = ALUC_MULTU; a8 = 8'd200; b8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        while (!done8 && edges < 50) begin @(posedge clk); #1; edges++; end
        n_checks++; if (edges !== 9) begin n_fail++; $display("FAIL w8_latency: done at edge %0d want 9", edges); end
        n_checks++; if (hi8 !== 8'h02 || lo8 !== 8'h58 || s8 !== 8'h58) begin n_fail++; $display("FAIL w8_multu: got hi=%h lo=%h s=%h want 02/58/58", hi8, lo8, s8); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shifts();
        test_multu();
        test_divu();
        test_back_to_back();
        test_reset_during_run();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
